trg_sci_rdout_arb: RTL and testbench

TRG_SCI_RDOUT_ARB -- requirements
Module: trg_sci_rdout_arb

---
 rtl/trg_sci_rdout_arb.sv | 156 +++++++++++++++
 tb/tb_trg_sci_rdout_arb.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trg_sci_rdout_arb.sv
// rtl/trg_sci_rdout_arb.sv - round-robin two-FIFO science readout framer
// Frames: header, {ch, frame_cnt}, PKT_LENn payload words, 16-bit additive checksum.
module trg_sci_rdout_arb #(
  parameter int          PKT_LEN0 = 16,
  parameter int          PKT_LEN1 = 8,
  parameter logic [15:0] HDR_WORD = 16'hEB90,
  parameter int          CNT_W    = 10
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             en_in,
  input  logic [15:0]      fifo0_data_in,
  input  logic             fifo0_empty_in,
  input  logic [CNT_W-1:0] fifo0_cnt_in,
  output logic             fifo0_rd_out,
  input  logic [15:0]      fifo1_data_in,
  input  logic             fifo1_empty_in,
  input  logic [CNT_W-1:0] fifo1_cnt_in,
  output logic             fifo1_rd_out,
  output logic [15:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready_in,
  output logic             out_sop,
  output logic             out_eop,
  output logic             busy_out,
  output logic             ch_sel_out,
  output logic [14:0]      frame_cnt_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_HEAD, S_INFO, S_RD, S_CAP, S_SEND, S_TAIL
  } state_t;

  state_t      state_q, state_d;
  logic        ch_sel_q, ch_sel_d;
  logic        last_q, last_d;
  logic [14:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] csum_q, csum_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [15:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        sop_q, sop_d;
  logic        eop_q, eop_d;

  logic        elig0, elig1, gnt, rd_go, last_word;
  logic [15:0] fifo_word;

  always_comb begin
    elig0     = en_in && (int'(fifo0_cnt_in) >= PKT_LEN0);
    elig1     = en_in && (int'(fifo1_cnt_in) >= PKT_LEN1);
    // Both eligible: the channel not served last wins; otherwise the lone one.
    gnt       = (elig0 && elig1) ? ~last_q : elig1;
    rd_go     = (state_q == S_RD) && (ch_sel_q ? !fifo1_empty_in : !fifo0_empty_in);
    last_word = ch_sel_q ? (wcnt_q == 16'(PKT_LEN1 - 1)) : (wcnt_q == 16'(PKT_LEN0 - 1));
    fifo_word = ch_sel_q ? fifo1_data_in : fifo0_data_in;

    state_d     = state_q;
    ch_sel_d    = ch_sel_q;
    last_d      = last_q;
    frame_cnt_d = frame_cnt_q;
    csum_d      = csum_q;
    wcnt_d      = wcnt_q;
    data_d      = data_q;
    valid_d     = valid_q;
    sop_d       = sop_q;
    eop_d       = eop_q;

    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        if (elig0 || elig1) begin
          ch_sel_d = gnt;
          csum_d   = '0;
          wcnt_d   = '0;
          data_d   = HDR_WORD;
          valid_d  = 1'b1;
          sop_d    = 1'b1;
          state_d  = S_HEAD;
        end
      end
      S_HEAD: if (out_ready_in) begin
        sop_d   = 1'b0;
        data_d  = {ch_sel_q, frame_cnt_q};
        state_d = S_INFO;
      end
      S_INFO: if (out_ready_in) begin
        valid_d = 1'b0;
        state_d = S_RD;
      end
      S_RD: if (rd_go) state_d = S_CAP;
      S_CAP: begin
        data_d  = fifo_word;
        csum_d  = csum_q + fifo_word;
        valid_d = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: if (out_ready_in) begin
        if (last_word) begin
          data_d  = csum_q;
          eop_d   = 1'b1;
          state_d = S_TAIL;
        end else begin
          wcnt_d  = wcnt_q + 16'd1;
          valid_d = 1'b0;
          state_d = S_RD;
        end
      end
      S_TAIL: if (out_ready_in) begin
        valid_d     = 1'b0;
        eop_d       = 1'b0;
        frame_cnt_d = frame_cnt_q + 15'd1;
        last_d      = ch_sel_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      ch_sel_q    <= 1'b0;
      last_q      <= 1'b1;
      frame_cnt_q <= '0;
      csum_q      <= '0;
      wcnt_q      <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_sel_q    <= ch_sel_d;
      last_q      <= last_d;
      frame_cnt_q <= frame_cnt_d;
      csum_q      <= csum_d;
      wcnt_q      <= wcnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
    end
  end

  // Strobe is issued in RD so the FIFO word is present during CAP.
  assign fifo0_rd_out  = rd_go && !ch_sel_q;
  assign fifo1_rd_out  = rd_go && ch_sel_q;
  assign out_data      = data_q;
  assign out_valid     = valid_q;
  assign out_sop       = sop_q;
  assign out_eop       = eop_q;
  assign busy_out      = (state_q != S_IDLE);
  assign ch_sel_out    = ch_sel_q;
  assign frame_cnt_out = frame_cnt_q;

endmodule

// File: tb/tb_trg_sci_rdout_arb.sv
// tb/tb_trg_sci_rdout_arb.sv - directed bench for trg_sci_rdout_arb
module tb_trg_sci_rdout_arb;

  localparam int L0 = 16;
  localparam int L1 = 8;

  logic        clk = 1'b0;
  logic        rst, en, ready;
  logic [15:0] fifo0_data_in = '0, fifo1_data_in = '0;
  logic        fifo0_empty_in, fifo1_empty_in;
  logic [9:0]  fifo0_cnt_in, fifo1_cnt_in;
  logic        fifo0_rd_out, fifo1_rd_out;
  logic [15:0] out_data;
  logic        out_valid, out_sop, out_eop, busy_out, ch_sel_out;
  logic [14:0] frame_cnt_out;

  always #10 clk = ~clk;

  trg_sci_rdout_arb dut (
    .clk_in(clk), .rst_in(rst), .en_in(en),
    .fifo0_data_in(fifo0_data_in), .fifo0_empty_in(fifo0_empty_in),
    .fifo0_cnt_in(fifo0_cnt_in), .fifo0_rd_out(fifo0_rd_out),
    .fifo1_data_in(fifo1_data_in), .fifo1_empty_in(fifo1_empty_in),
    .fifo1_cnt_in(fifo1_cnt_in), .fifo1_rd_out(fifo1_rd_out),
    .out_data(out_data), .out_valid(out_valid), .out_ready_in(ready),
    .out_sop(out_sop), .out_eop(out_eop), .busy_out(busy_out),
    .ch_sel_out(ch_sel_out), .frame_cnt_out(frame_cnt_out)
  );

  // FIFO models: memories filled by the stimulus, popped on the read strobe
  logic [15:0] mem0 [0:1023];
  logic [15:0] mem1 [0:1023];
  logic [9:0]  wp0 = '0, rp0 = '0, wp1 = '0, rp1 = '0;
  logic        hold0 = 1'b0;
  logic        rd0_s = 1'b0, rd1_s = 1'b0;
  logic [15:0] exp0[$], exp1[$];

  assign fifo0_cnt_in   = wp0 - rp0;
  assign fifo1_cnt_in   = wp1 - rp1;
  assign fifo0_empty_in = (wp0 == rp0) || hold0;
  assign fifo1_empty_in = (wp1 == rp1);

  always @(negedge clk) begin
    rd0_s <= fifo0_rd_out;
    rd1_s <= fifo1_rd_out;
  end

  always @(posedge clk) begin
    if (rd0_s) begin
      fifo0_data_in <= mem0[rp0];
      rp0 <= rp0 + 10'd1;
    end
    if (rd1_s) begin
      fifo1_data_in <= mem1[rp1];
      rp1 <= rp1 + 10'd1;
    end
  end

  int checks = 0, errors = 0;
  int rd0_n = 0, rd1_n = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct { logic [15:0] d; logic s; logic e; } beat_t;
  beat_t       obs[$];
  logic        stall_p = 1'b0;
  logic [15:0] stall_d = '0;

  // Output monitor: record accepted beats, verify stall stability and strobe legality
  always @(negedge clk) begin
    beat_t b;
    if (fifo0_rd_out) rd0_n++;
    if (fifo1_rd_out) rd1_n++;
    if (fifo0_rd_out || fifo1_rd_out)
      chk("rd_legal", {fifo0_rd_out && fifo1_rd_out, ch_sel_out !== fifo1_rd_out,
                       fifo0_rd_out && fifo0_empty_in, fifo1_rd_out && fifo1_empty_in}, 4'b0000);
    if (stall_p && !rst) chk("stall_hold", {out_valid, out_data}, {1'b1, stall_d});
    if (out_valid && ready && !rst) begin
      b.d = out_data; b.s = out_sop; b.e = out_eop;
      obs.push_back(b);
    end
    stall_p = out_valid && !ready && !rst;
    stall_d = out_data;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input bit ch, input int n, input logic [15:0] base, input logic [15:0] step);
    logic [15:0] w;
    for (int i = 0; i < n; i++) begin
      w = base + 16'(i) * step;
      if (ch) begin mem1[wp1] = w; exp1.push_back(w); wp1 = wp1 + 10'd1; end
      else    begin mem0[wp0] = w; exp0.push_back(w); wp0 = wp0 + 10'd1; end
    end
  endtask

  task automatic wait_frames(input int n);
    int k = 0;
    while (frame_cnt_out !== 15'(n) && k < 3000) begin cyc(1); k++; end
    chk("frame_wait", {17'd0, frame_cnt_out}, n);
  endtask

  task automatic check_frame(input bit ch, input logic [14:0] fc, input string tag);
    int          n;
    logic [15:0] sum, w;
    beat_t       b;
    n   = ch ? L1 : L0;
    sum = '0;
    chk({tag, "_len"}, obs.size() >= n + 3, 1);
    if (obs.size() < n + 3) return;
    b = obs.pop_front();
    chk({tag, "_hdr"}, {b.d, b.s, b.e}, {16'hEB90, 2'b10});
    b = obs.pop_front();
    chk({tag, "_info"}, {b.d, b.s, b.e}, {ch, fc, 2'b00});
    for (int i = 0; i < n; i++) begin
      w   = ch ? exp1.pop_front() : exp0.pop_front();
      sum = sum + w;
      b   = obs.pop_front();
      chk({tag, "_pay"}, {b.d, b.s, b.e}, {w, 2'b00});
    end
    b = obs.pop_front();
    chk({tag, "_csum"}, {b.d, b.s, b.e}, {sum, 2'b01});
  endtask

  initial begin
    int k, n0;
    rst = 1'b1; en = 1'b0; ready = 1'b0;
    cyc(3);
    chk("rst_valid", out_valid, 0);
    chk("rst_sopeop", {out_sop, out_eop}, 0);
    chk("rst_data", out_data, 0);
    chk("rst_rd", {fifo0_rd_out, fifo1_rd_out}, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_fcnt", frame_cnt_out, 0);
    rst = 1'b0; en = 1'b1; ready = 1'b1;
    cyc(2);

    // Basic ch0 frame: words 1..16, checksum 0x0088
    push(0, 16, 16'd1, 16'd1);
    wait_frames(1);
    cyc(2);
    chk("f036_nbeats", obs.size(), 19);
    if (obs.size() == 19) chk("f036_csum_const", obs[18].d, 16'h0088);
    check_frame(0, 15'd0, "f036");
    chk("f036_rd0", rd0_n, 16);
    chk("f036_rd1", rd1_n, 0);

    // Threshold: 15 words is not enough, the 16th starts a frame
    push(0, 15, 16'hF000, 16'h0111);
    cyc(20);
    chk("f039_idle_busy", busy_out, 0);
    chk("f039_idle_obs", obs.size(), 0);
    chk("f039_idle_rd", rd0_n, 16);
    push(0, 1, 16'hFFFF, 16'h0000);
    cyc(2);
    chk("f039_start", busy_out, 1);
    wait_frames(2);
    cyc(2);
    check_frame(0, 15'd1, "f039");

    // Both eligible: alternate, ch1 first since ch0 was served last
    push(0, 32, 16'h2000, 16'd3);
    push(1, 16, 16'h3000, 16'd5);
    wait_frames(6);
    cyc(2);
    check_frame(1, 15'd2, "f037a");
    check_frame(0, 15'd3, "f037b");
    check_frame(1, 15'd4, "f037c");
    check_frame(0, 15'd5, "f037d");
    chk("f037_left", obs.size(), 0);

    // Backpressure on payload word 3
    push(0, 16, 16'h4000, 16'd7);
    k = 0;
    while (!(obs.size() == 4 && out_valid === 1'b1) && k < 500) begin cyc(1); k++; end
    chk("f038_reach", obs.size() == 4 && out_valid === 1'b1, 1);
    ready = 1'b0;
    n0 = rd0_n;
    cyc(5);
    chk("f038_noread", rd0_n, n0);
    chk("f038_nobeat", obs.size(), 4);
    ready = 1'b1;
    wait_frames(7);
    cyc(2);
    check_frame(0, 15'd6, "f038");

    // FIFO runs dry after the 4th read: FSM parks in RD without strobes
    push(0, 16, 16'h5000, 16'h0101);
    n0 = rd0_n;
    k  = 0;
    while (rd0_n != n0 + 4 && k < 500) begin cyc(1); k++; end
    hold0 = 1'b1;
    cyc(10);
    chk("f040_wait_rd", rd0_n, n0 + 4);
    chk("f040_wait_busy", {busy_out, out_valid}, 2'b10);
    hold0 = 1'b0;
    wait_frames(8);
    cyc(2);
    check_frame(0, 15'd7, "f040a");

    // en_in dropped mid-frame: frame completes, nothing further starts
    push(0, 16, 16'h6000, 16'd1);
    push(1, 8, 16'h7000, 16'h1111);
    k = 0;
    while (busy_out !== 1'b1 && k < 50) begin cyc(1); k++; end
    en = 1'b0;
    wait_frames(9);
    cyc(30);
    chk("f040b_idle", busy_out, 0);
    chk("f040b_fcnt", frame_cnt_out, 9);
    check_frame(1, 15'd8, "f040b");
    chk("f040b_left", obs.size(), 0);

    // Reset during SEND of payload word 2
    en = 1'b1;
    n0 = rd0_n;
    k  = 0;
    while (!(obs.size() == 3 && out_valid === 1'b1) && k < 500) begin cyc(1); k++; end
    chk("f041_reach", obs.size() == 3 && out_valid === 1'b1, 1);
    rst = 1'b1;
    #1;
    chk("f041_rst_out", {out_valid, out_sop, out_eop, fifo0_rd_out, fifo1_rd_out, busy_out}, 0);
    chk("f041_rst_data", out_data, 0);
    chk("f041_rst_fcnt", frame_cnt_out, 0);
    for (int i = 0; i < rd0_n - n0; i++) void'(exp0.pop_front());
    obs.delete();
    cyc(3);
    chk("f041_rst_reads", rd0_n - n0, 2);
    push(0, 2, 16'h8000, 16'd9);
    push(1, 8, 16'h9000, 16'h2002);
    rst = 1'b0;
    wait_frames(2);
    cyc(2);
    check_frame(0, 15'd0, "f041a");
    check_frame(1, 15'd1, "f041b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
